ram_reader: RTL and testbench
=============================

RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 Parameter AW, default 5, address width; RAM depth is 2^AW words.
REQ-002 Parameter DW, default 2, data word width.
REQ-003 clk_i  in  1  single clock; all logic on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-low.
REQ-005 ena_i  in  1  global enable; low freezes all state.
REQ-006 start_i  in  1  start a burst read; honoured only in IDLE.
REQ-007 base_i  in  AW  first word address, sampled with start_i.
REQ-008 len_i  in  AW+1  word count 0..2^AW, sampled with start_i.
REQ-009 stop_i  in  1  terminate loop playback (RAMRD_LOOP_EN only).
REQ-010 xadr_o  out  AW  address to the RAM read-only port.
REQ-011 xdat_i  in  DW  combinational read data from the RAM read-only port.
REQ-012 dat_o  out  DW  output word.
REQ-013 stb_o  out  1  dat_o valid.
REQ-014 ack_i  in  1  consumer accepts dat_o when stb_o&ack_i.
REQ-015 busy_o  out  1  high in READ or DRAIN.
REQ-016 done_o  out  1  one-cycle pulse at burst completion.

Function
REQ-017 States: IDLE, READ, DRAIN; busy_o = (state != IDLE).
REQ-018 IDLE: start_i&ena_i with len_i>0 latches base_i and len_i into addr/remaining and enters READ; with len_i=0 the block stays IDLE and pulses done_o next cycle, and stb_o never asserts.
REQ-019 start_i SHALL be ignored outside IDLE.
REQ-020 xadr_o = current address register; xdat_i is captured into a one-word output register.
REQ-021 READ: capture occurs when the output register is empty or stb_o&ack_i in the same cycle; each capture sets stb_o, increments addr modulo 2^AW, and decrements remaining.
REQ-022 Throughput: one word per cycle when ack_i is held high.
REQ-023 Latency: start_i sampled at edge N -> xadr_o=base_i after N -> stb_o with dat_o=RAM[base_i] after edge N+1.
REQ-024 When the capture with remaining=1 occurs, state -> DRAIN.
REQ-025 DRAIN: on stb_o&ack_i, stb_o clears, done_o pulses for one cycle, and the state returns to IDLE.
REQ-026 stb_o&!ack_i: dat_o and stb_o hold stable, and addr does not advance.
REQ-027 Address wrap: base_i+len_i > 2^AW wraps to address 0 with no error.
REQ-028 ena_i low: no state, register, or output change; done_o is not emitted.

Reset
REQ-029 rst_i low at an edge forces IDLE, with stb_o=0, done_o=0, busy_o=0, dat_o=0, xadr_o=0, and remaining=0.
REQ-030 Reset mid-burst aborts the burst: the buffered word is discarded and done_o is not emitted.

Configuration
REQ-031 Macro RAMRD_LOOP_EN defined: in READ, the capture with remaining=1 reloads addr=base and remaining=len and stays in READ (continuous playback); stop_i high in READ blocks further captures and moves to DRAIN; stop_i is ignored in IDLE and DRAIN.
REQ-032 RAMRD_LOOP_EN undefined: stop_i is ignored, and every burst ends after len words per REQ-024.

Verification
REQ-033 RAM[3..6]=1,2,3,0, base=3, len=4, ack=1 -> stb high for 4 cycles starting 2 cycles after start; dat 1,2,3,0; done pulse after last ack; busy low thereafter.
REQ-034 Same burst, ack toggled 1,0,0,1,... -> no word lost or duplicated; dat held during ack=0.
REQ-035 AW=5, base=30, len=4 -> xadr sequence 30,31,0,1.
REQ-036 len=0 -> done pulse 1 cycle after start, stb never high; start during busy -> ignored, burst unchanged.
REQ-037 rst low after 2 words of a len=8 burst -> next cycle stb=0, busy=0, no done; ena low for 3 cycles mid-burst -> outputs frozen, sequence resumes intact.
REQ-038 RAMRD_LOOP_EN defined, base=2, len=2 -> dat repeats RAM[2],RAM[3],RAM[2],...; stop pulse -> at most one further word, then done pulse.

Source files
------------

// File: rtl/ram_reader.sv
// Burst reader for a RAM with a combinational read-only port.
// Reads len words starting at base (address wraps modulo 2^AW) and presents them one at a time
// on a stb/ack handshake through a single-word output register.
// Optional feature: define RAMRD_LOOP_EN for continuous playback of the burst until stop_i.
module ram_reader #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW:0]   len_i,
    input  logic          stop_i,
    output logic [AW-1:0] xadr_o,
    input  logic [DW-1:0] xdat_i,
    output logic [DW-1:0] dat_o,
    output logic          stb_o,
    input  logic          ack_i,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          stb_q, stb_d;
    logic          done_q, done_d;
    logic          take;

`ifdef RAMRD_LOOP_EN
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   len_q, len_d;
`else
    logic unused_stop;
    assign unused_stop = stop_i;
`endif

    // Output register can accept a new word when empty or being drained this cycle.
    assign take = !stb_q || ack_i;

    // Next-state logic for the burst sequencer and the output register.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        dat_d   = dat_q;
        stb_d   = stb_q;
        done_d  = 1'b0;
`ifdef RAMRD_LOOP_EN
        base_d  = base_q;
        len_d   = len_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        addr_d  = base_i;
                        rem_d   = len_i;
                        state_d = StRead;
`ifdef RAMRD_LOOP_EN
                        base_d  = base_i;
                        len_d   = len_i;
`endif
                    end else begin
                        // Empty burst completes immediately without producing data.
                        done_d = 1'b1;
                    end
                end
            end
            StRead: begin
`ifdef RAMRD_LOOP_EN
                if (stop_i) begin
                    state_d = StDrain;
                    if (stb_q && ack_i) begin
                        stb_d = 1'b0;
                    end
                end else if (take) begin
                    dat_d = xdat_i;
                    stb_d = 1'b1;
                    if (rem_q == (AW+1)'(1)) begin
                        // Restart the same burst for continuous playback.
                        addr_d = base_q;
                        rem_d  = len_q;
                    end else begin
                        addr_d = addr_q + AW'(1);
                        rem_d  = rem_q - (AW+1)'(1);
                    end
                end
`else
                if (take) begin
                    dat_d  = xdat_i;
                    stb_d  = 1'b1;
                    addr_d = addr_q + AW'(1);
                    rem_d  = rem_q - (AW+1)'(1);
                    if (rem_q == (AW+1)'(1)) begin
                        state_d = StDrain;
                    end
                end
`endif
            end
            StDrain: begin
                // Empty register is possible only after a stop with nothing left buffered.
                if (take) begin
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; ena_i low freezes everything, reset is synchronous active-low.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            dat_q   <= '0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef RAMRD_LOOP_EN
            base_q  <= '0;
            len_q   <= '0;
`endif
        end else if (ena_i) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
`ifdef RAMRD_LOOP_EN
            base_q  <= base_d;
            len_q   <= len_d;
`endif
        end
    end

    assign xadr_o = addr_q;
    assign dat_o  = dat_q;
    assign stb_o  = stb_q;
    assign busy_o = (state_q != StIdle);
    // A frozen pulse is only seen during an enabled cycle.
    assign done_o = done_q && ena_i;

endmodule

// File: tb/tb_ram_reader.sv
// Self-checking bench for ram_reader: random bursts checked against a queue-based reference.
module tb_ram_reader;
    localparam int AW    = 5;
    localparam int DW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, ena, start, stop, ack;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [AW-1:0] xadr;
    logic [DW-1:0] xdat, dat;
    logic          stb, busy, done;
    logic [DW-1:0] ram [DEPTH];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign xdat = ram[xadr];

    ram_reader #(.AW(AW), .DW(DW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .ena_i  (ena),
        .start_i(start),
        .base_i (base),
        .len_i  (len),
        .stop_i (stop),
        .xadr_o (xadr),
        .xdat_i (xdat),
        .dat_o  (dat),
        .stb_o  (stb),
        .ack_i  (ack),
        .busy_o (busy),
        .done_o (done)
    );

    task automatic test_reset();
        rst = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0; base = '0; len = '0;
        repeat (2) @(negedge clk);
        vectors += 5;
        if (stb !== 1'b0) begin miscompares++; $display("FAIL reset_stb got %b exp 0", stb); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
        if (dat !== '0) begin miscompares++; $display("FAIL reset_dat got %0h exp 0", dat); end
        if (xadr !== '0) begin miscompares++; $display("FAIL reset_xadr got %0d exp 0", xadr); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One burst: reference is the list of RAM words at (b+i) mod DEPTH, in order, each exactly once.
    task automatic test_burst(input int b, input int l, input int ack_pct, input bit ena_gap,
                              input bit poke);
        logic [AW-1:0] exp_addr [$];
        logic [DW-1:0] exp_dat [$];
        int            issued = 0;
        int            got = 0;
        int            cyc = 0;
        bit            fin = 1'b0;
        bit            prev_hold = 1'b0;
        logic [DW-1:0] prev_dat = '0;
        for (int i = 0; i < l; i++) begin
            exp_addr.push_back(AW'((b + i) % DEPTH));
            exp_dat.push_back(ram[(b + i) % DEPTH]);
        end
        start = 1'b1; base = AW'(b); len = (AW+1)'(l); ack = 1'b0; ena = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (l == 0) begin
            vectors += 3;
            if (done !== 1'b1) begin miscompares++; $display("FAIL len0_done got %b exp 1", done); end
            if (stb !== 1'b0) begin miscompares++; $display("FAIL len0_stb got %b exp 0", stb); end
            if (busy !== 1'b0) begin miscompares++; $display("FAIL len0_busy got %b exp 0", busy); end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin miscompares++; $display("FAIL len0_done2 got %b exp 0", done); end
            return;
        end
        vectors += 2;
        if (stb !== 1'b0) begin miscompares++; $display("FAIL latency_stb got %b exp 0", stb); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL start_busy got %b exp 1", busy); end
        while (!fin && cyc < 400) begin
            ena   = !(ena_gap && cyc >= 3 && cyc < 6);
            ack   = ($urandom_range(99) < ack_pct);
            start = poke && (cyc == 2);
            if (start) begin
                base = AW'($urandom);
                len  = (AW+1)'($urandom_range(1, DEPTH));
            end
            if (got == l) begin
                start = 1'b0;
                vectors += 3;
                if (done !== 1'b1) begin miscompares++; $display("FAIL done_pulse got %b exp 1", done); end
                if (busy !== 1'b0) begin miscompares++; $display("FAIL end_busy got %b exp 0", busy); end
                if (stb !== 1'b0) begin miscompares++; $display("FAIL end_stb got %b exp 0", stb); end
                fin = 1'b1;
            end else begin
                vectors++;
                if (done !== 1'b0) begin miscompares++; $display("FAIL early_done got %b exp 0", done); end
                if (prev_hold) begin
                    vectors++;
                    if (stb !== 1'b1 || dat !== prev_dat) begin
                        miscompares++;
                        $display("FAIL hold got stb=%b dat=%0h exp stb=1 dat=%0h", stb, dat, prev_dat);
                    end
                end
                if (ena && issued < l && (!stb || ack)) begin
                    vectors++;
                    if (xadr !== exp_addr[issued]) begin
                        miscompares++;
                        $display("FAIL xadr[%0d] got %0d exp %0d", issued, xadr, exp_addr[issued]);
                    end
                    issued++;
                end
                prev_hold = stb && !(ack && ena);
                prev_dat  = dat;
                if (stb && ack && ena) begin
                    vectors++;
                    if (dat !== exp_dat[got]) begin
                        miscompares++;
                        $display("FAIL dat[%0d] got %0h exp %0h", got, dat, exp_dat[got]);
                    end
                    got++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; ack = 1'b0; ena = 1'b1;
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL burst_timeout got %0d words exp %0d", got, l);
        end else if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_width got %b exp 0", done);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; base = AW'($urandom); len = (AW+1)'(8); ack = 1'b1; ena = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors += 5;
        if (stb !== 1'b0) begin miscompares++; $display("FAIL rstmid_stb got %b exp 0", stb); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b exp 0", done); end
        if (dat !== '0) begin miscompares++; $display("FAIL rstmid_dat got %0h exp 0", dat); end
        if (xadr !== '0) begin miscompares++; $display("FAIL rstmid_xadr got %0d exp 0", xadr); end
        rst = 1'b1; ack = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done2 got %b exp 0", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy2 got %b exp 0", busy); end
    endtask

`ifdef RAMRD_LOOP_EN
    task automatic test_loop();
        int got = 0;
        int extra = 0;
        int cyc = 0;
        bit seen_done = 1'b0;
        start = 1'b1; base = AW'(2); len = (AW+1)'(2); ack = 1'b1; ena = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (got < 6 && cyc < 50) begin
            if (stb) begin
                vectors++;
                if (dat !== ram[2 + (got % 2)]) begin
                    miscompares++;
                    $display("FAIL loop_dat[%0d] got %0h exp %0h", got, dat, ram[2 + (got % 2)]);
                end
                got++;
            end
            cyc++;
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 10 && !seen_done; i++) begin
            if (stb) extra++;
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        vectors += 2;
        if (extra > 1) begin miscompares++; $display("FAIL loop_extra got %0d exp <=1", extra); end
        if (!seen_done) begin miscompares++; $display("FAIL loop_done got 0 exp 1"); end
        ack = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
        @(negedge clk);
        test_reset();
        // Directed burst: RAM[3..6] = 1,2,3,0.
        ram[3] = 2'd1; ram[4] = 2'd2; ram[5] = 2'd3; ram[6] = 2'd0;
        test_burst(3, 4, 100, 1'b0, 1'b0);
        test_burst(3, 4, 50, 1'b0, 1'b0);
        test_burst(30, 4, 100, 1'b0, 1'b0);
        test_burst(5, 0, 100, 1'b0, 1'b0);
        test_burst(int'($urandom_range(0, DEPTH - 1)), 8, 70, 1'b0, 1'b1);
        test_burst(int'($urandom_range(0, DEPTH - 1)), 10, 100, 1'b1, 1'b0);
        test_burst(7, DEPTH, 60, 1'b0, 1'b0);
        test_burst(31, 1, 40, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
            test_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)),
                       int'($urandom_range(30, 100)), 1'($urandom), 1'b0);
        end
        test_reset_mid();
`ifdef RAMRD_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
